// File: rtl/pic16f84_seq.sv
// PIC16F84 instruction-cycle sequencer: Q1..Q4 phase generation, fetch/execute pipeline, SLEEP/wake.
// Optional HALT/single-step debug support is compiled in with macro PIC16F84_SEQ_STEP_EN.
//
// state | meaning
// RESET | held after mclr; waits for synchronised reset release
// RUN   | phases advance each clk, one instruction per four clocks
// SLEEP | clocks to the CPU stopped until wake
// HALT  | debug stop; step edge runs one cycle (PIC16F84_SEQ_STEP_EN only)
module pic16f84_seq (
    input  logic        clk,
    input  logic        mclr,
    input  logic [12:0] pc_in,
    input  logic        flush,
    input  logic        sleep_req,
    input  logic        wake,
    input  logic [13:0] prog_data,
`ifdef PIC16F84_SEQ_STEP_EN
    input  logic        halt,
    input  logic        step,
`endif
    output logic [12:0] prog_addr,
    output logic        q1,
    output logic        q2,
    output logic        q3,
    output logic        q4,
    output logic [13:0] op_code,
    output logic        sleeping,
    output logic [15:0] cycle_count
);

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_SLEEP = 2'd2;
`ifdef PIC16F84_SEQ_STEP_EN
    localparam logic [1:0] ST_HALT  = 2'd3;
`endif

    logic        rel_q;
    logic [1:0]  state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [12:0] addr_q, addr_d;
    logic [13:0] ir_q, ir_d;
    logic [15:0] cnt_q, cnt_d;
`ifdef PIC16F84_SEQ_STEP_EN
    logic        step_q;
`endif

    // rel_q is the first release flop; the state register is the second, so RUN starts on edge two.
    always_ff @(posedge clk or negedge mclr) begin
        if (!mclr) begin
            rel_q <= 1'b0;
        end else begin
            rel_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RESET: begin
                if (rel_q) begin
                    state_d = ST_RUN;
                    phase_d = 2'd0;
                end
            end
            ST_RUN: begin
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd0) begin
                    addr_d = pc_in;
                end
                if (phase_q == 2'd3) begin
                    ir_d  = flush ? 14'h0000 : prog_data;
                    cnt_d = cnt_q + 16'd1;
                    if (sleep_req && !wake) begin
                        state_d = ST_SLEEP;
                    end
`ifdef PIC16F84_SEQ_STEP_EN
                    else if (halt) begin
                        state_d = ST_HALT;
                    end
`endif
                end
            end
            ST_SLEEP: begin
                if (wake) begin
                    state_d = ST_RUN;
                    phase_d = 2'd0;
                end
            end
`ifdef PIC16F84_SEQ_STEP_EN
            ST_HALT: begin
                // A step runs one cycle in RUN; halt still high at its Q4 edge brings us back here.
                if (!halt || (step && !step_q)) begin
                    state_d = ST_RUN;
                    phase_d = 2'd0;
                end
            end
`endif
            default: begin
                state_d = ST_RESET;
                phase_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge mclr) begin
        if (!mclr) begin
            state_q <= ST_RESET;
            phase_q <= 2'd0;
            addr_q  <= 13'd0;
            ir_q    <= 14'h0000;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIC16F84_SEQ_STEP_EN
    always_ff @(posedge clk or negedge mclr) begin
        if (!mclr) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end
`endif

    assign q1          = (state_q == ST_RUN) && (phase_q == 2'd0);
    assign q2          = (state_q == ST_RUN) && (phase_q == 2'd1);
    assign q3          = (state_q == ST_RUN) && (phase_q == 2'd2);
    assign q4          = (state_q == ST_RUN) && (phase_q == 2'd3);
    assign prog_addr   = addr_q;
    assign op_code     = ir_q;
    assign sleeping    = (state_q == ST_SLEEP);
    assign cycle_count = cnt_q;

endmodule

// File: doc/pic16f84_seq.md
PIC16F84_SEQ -- requirements
Module: pic16f84_seq

Interface
REQ-001 SHALL have port: clk  input  1  single system oscillator clock; every flop changes on its rising edge.
REQ-002 SHALL have port: mclr  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: pc_in  input  13  current program counter from the CPU (pc_out).
REQ-004 SHALL have port: flush  input  1  the CPU executed a branch this cycle (nop_out); discard the prefetched instruction.
REQ-005 SHALL have port: sleep_req  input  1  the CPU executed SLEEP this cycle.
REQ-006 SHALL have port: wake  input  1  level wake event, interrupt or WDT.
REQ-007 SHALL have port: prog_data  input  14  program-memory read data, valid by the Q4 phase.
REQ-008 SHALL have port: prog_addr  output  13  program-memory fetch address.
REQ-009 SHALL have ports: q1, q2, q3, q4  output  1 each  one-hot quadrature phases to the CPU.
REQ-010 SHALL have port: op_code  output  14  instruction to execute this cycle.
REQ-011 SHALL have port: sleeping  output  1  high while in SLEEP.
REQ-012 SHALL have port: cycle_count  output  16  completed instruction cycles.

Function
REQ-013 SHALL implement states RESET, RUN and SLEEP, plus HALT when the macro is defined, with a 2-bit phase counter.
REQ-014 In RUN, phase SHALL advance 0->1->2->3->0 once per clk, and qN SHALL be high exactly when phase==N-1; other states SHALL drive all q* low.
REQ-015 prog_addr SHALL register pc_in on the clk edge that ends phase 0 (Q1).
REQ-016 On the edge ending phase 3 (Q4), the instruction register SHALL load prog_data, or 14'h0000 (NOP) if flush is high on that edge.
REQ-017 op_code SHALL equal the instruction register, giving a two-cycle fetch/execute pipeline: fetch in cycle N, execute in cycle N+1.
REQ-018 cycle_count SHALL increment by 1 on every edge ending Q4 in RUN, and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-019 sleep_req high at the edge ending Q4 SHALL move RUN->SLEEP and assert sleeping from the next clk, unless wake is also high on that edge, in which case the block stays in RUN.
REQ-020 In SLEEP, wake high at any clk edge SHALL move to RUN with phase 0 and deassert sleeping; the instruction register is retained and executes in that first cycle.
REQ-021 flush and sleep_req together SHALL apply both: the NOP loads and SLEEP is entered.
REQ-022 flush, sleep_req and wake SHALL be ignored outside the sampling points defined above.

Reset
REQ-023 mclr low SHALL immediately force: state RESET, phase 0, q1..q4=0, op_code=14'h0000, prog_addr=0, sleeping=0, cycle_count=0.
REQ-024 Reset release SHALL be synchronised through 2 flops, and RESET SHALL move to RUN on the second clk edge after mclr rises, with the first cycle executing NOP.
REQ-025 mclr asserted mid-cycle or during SLEEP/HALT SHALL abort with the reset values above, and no partial phase sequence SHALL complete.

Configuration
REQ-026 With macro PIC16F84_SEQ_STEP_EN defined, the block SHALL add inputs halt and step (1 bit each) and state HALT.
REQ-027 With the macro defined, halt high at the edge ending Q4 SHALL enter HALT with q* low and all registers held.
REQ-028 With the macro defined, a step rising edge in HALT SHALL run exactly one full Q1..Q4 cycle and then return to HALT; halt low SHALL resume RUN at phase 0.
REQ-029 With the macro defined, sleep_req SHALL have priority over halt at the same edge.
REQ-030 With the macro undefined, the ports and state SHALL be absent and behaviour SHALL be identical to the RUN/SLEEP machine above.

Verification
REQ-031 mclr low 3 clk then high -> q* low for 2 clk, then q1 high on the 3rd edge; op_code=0000 for the first 4 clk; cycle_count=1 after them.
REQ-032 pc_in=0x005 with prog_data=0x23D5 -> prog_addr=0x005 after Q1; op_code=0x23D5 in the following cycle.
REQ-033 flush=1 at the Q4 edge with prog_data=0x3FFF -> op_code=0x0000 next cycle, and the fetch resumes from the new pc_in.
REQ-034 sleep_req=1 at Q4 -> sleeping=1 and q* frozen low; wake=1 after 10 clk -> q1 high on the next edge, op_code retained; sleep_req and wake both high -> no sleep.
REQ-035 Preload cycle_count to 0xFFFF, or run 65535 cycles, -> one further cycle gives 0x0000; mclr pulsed low during Q3 -> all outputs reset within the same time step.
REQ-036 With PIC16F84_SEQ_STEP_EN defined: halt=1 -> HALT after Q4; three step pulses -> cycle_count advances by exactly 3.
